// File: rtl/m2_bram_arbiter.sv
// Round-robin arbiter for three requesters sharing the M2 BRAM port.
// Define M2_ARB_BURST_LIMIT_EN to force a yield after 16 back-to-back transfers.
module m2_bram_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   req,
  input  logic [2:0]   we,
  input  logic [7:0]   addr0,
  input  logic [7:0]   addr1,
  input  logic [7:0]   addr2,
  input  logic [127:0] wdata0,
  input  logic [127:0] wdata1,
  input  logic [127:0] wdata2,
  output logic [2:0]   gnt,
  output logic [2:0]   rvalid,
  output logic         M2_WEN,
  output logic [7:0]   M2_WAd,
  output logic [127:0] M2_WData,
  output logic [2:0]   M2_RAd
);

  typedef enum logic [1:0] {
    OWN_0    = 2'd0,
    OWN_1    = 2'd1,
    OWN_2    = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  owner_t       owner, owner_nxt, last_owner;
  logic [2:0]   acc;
  logic         acc_any;
  logic         yield;
  logic         sel_we;
  logic [7:0]   sel_addr;
  logic [127:0] sel_wdata;
  logic [2:0]   rd_pend;

  // First requester found after 'from' in 0->1->2->0 order; 'from' itself is last.
  function automatic owner_t rr_pick(input owner_t from, input logic [2:0] r);
    owner_t     pick;
    logic [1:0] idx;
    pick = OWN_NONE;
    for (int unsigned k = 3; k >= 1; k--) begin
      idx = 2'((32'(from) + k) % 3);
      if (r[idx]) pick = owner_t'(idx);
    end
    return pick;
  endfunction

  function automatic logic [2:0] onehot(input owner_t o);
    logic [2:0] v;
    v = '0;
    case (o)
      OWN_0:   v = 3'b001;
      OWN_1:   v = 3'b010;
      OWN_2:   v = 3'b100;
      default: v = '0;
    endcase
    return v;
  endfunction

  // gnt always mirrors owner, so req & gnt is exactly "owner is requesting".
  assign acc     = req & gnt;
  assign acc_any = |acc;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (owner)
      OWN_0:   begin sel_we = we[0]; sel_addr = addr0; sel_wdata = wdata0; end
      OWN_1:   begin sel_we = we[1]; sel_addr = addr1; sel_wdata = wdata1; end
      OWN_2:   begin sel_we = we[2]; sel_addr = addr2; sel_wdata = wdata2; end
      default: begin sel_we = 1'b0;  sel_addr = '0;    sel_wdata = '0;     end
    endcase
  end

`ifdef M2_ARB_BURST_LIMIT_EN
  logic [3:0] burst_cnt;

  // Yield parks the grant at none for one cycle so the handover idles M2 like a normal drop.
  assign yield = acc_any && (burst_cnt == 4'hF) && |(req & ~gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  burst_cnt <= '0;
    else if (owner_nxt != owner) burst_cnt <= '0;
    else if (acc_any)            burst_cnt <= burst_cnt + 4'd1;
  end
`else
  assign yield = 1'b0;
`endif

  always_comb begin
    owner_nxt = owner;
    if (yield)         owner_nxt = OWN_NONE;
    else if (!acc_any) owner_nxt = rr_pick(last_owner, req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_NONE;
      last_owner <= OWN_2;
      gnt        <= '0;
      rd_pend    <= '0;
      rvalid     <= '0;
      M2_WEN     <= 1'b0;
      M2_WAd     <= '0;
      M2_WData   <= '0;
      M2_RAd     <= '0;
    end else begin
      owner <= owner_nxt;
      if (owner_nxt != OWN_NONE) last_owner <= owner_nxt;
      gnt     <= onehot(owner_nxt);
      rd_pend <= acc & ~we;
      rvalid  <= rd_pend;
      M2_WEN   <= acc_any & sel_we;
      M2_WAd   <= (acc_any && sel_we)  ? sel_addr      : '0;
      M2_WData <= (acc_any && sel_we)  ? sel_wdata     : '0;
      M2_RAd   <= (acc_any && !sel_we) ? sel_addr[2:0] : '0;
    end
  end

endmodule

// File: tb/tb_m2_bram_arbiter.sv
// Scoreboard bench for m2_bram_arbiter: an independent arbitration model
// predicts gnt, M2 port drive and rvalid each cycle.
module tb_m2_bram_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req, we;
  logic [7:0]   addr0, addr1, addr2;
  logic [127:0] wdata0, wdata1, wdata2;
  logic [2:0]   gnt, rvalid;
  logic         M2_WEN;
  logic [7:0]   M2_WAd;
  logic [127:0] M2_WData;
  logic [2:0]   M2_RAd;

  always #5 clk = ~clk;

  m2_bram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid),
    .M2_WEN(M2_WEN), .M2_WAd(M2_WAd), .M2_WData(M2_WData), .M2_RAd(M2_RAd)
  );

  typedef struct packed {
    logic         wen;
    logic [7:0]   wad;
    logic [127:0] wdata;
    logic [2:0]   rad;
  } m2_t;

  m2_t         m2_q[$];
  logic [2:0]  rv_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          m_owner, m_last, m_cnt;
  logic [2:0]  m_gnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] addr_of(input int i);
    return (i == 0) ? addr0 : (i == 1) ? addr1 : addr2;
  endfunction

  function automatic logic [127:0] wdata_of(input int i);
    return (i == 0) ? wdata0 : (i == 1) ? wdata1 : wdata2;
  endfunction

  task automatic clear_inputs();
    req = '0; we = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
  endtask

  // Called at a negedge; holds rst_n low across two rising edges.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("rst_gnt",    128'(gnt),      '0);
    check("rst_rvalid", 128'(rvalid),   '0);
    check("rst_wen",    128'(M2_WEN),   '0);
    check("rst_wad",    128'(M2_WAd),   '0);
    check("rst_wdata",  M2_WData,       '0);
    check("rst_rad",    128'(M2_RAd),   '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m2_q.delete();
    rv_q.delete();
    rv_q.push_back(3'b000);
    m_owner = 3; m_last = 2; m_cnt = 0; m_gnt = '0;
  endtask

  // One clock cycle: predict from current inputs, advance, compare at the next negedge.
  task automatic cyc();
    m2_t        e, o;
    logic [2:0] acc, rv;
    logic [7:0] a;
    bit         yld;
    int         nxt;
    acc = req & m_gnt;
    e   = '0;
    if (acc != 3'b000) begin
      a = addr_of(m_owner);
      if (we[m_owner]) begin
        e.wen = 1'b1; e.wad = a; e.wdata = wdata_of(m_owner);
      end else begin
        e.rad = a[2:0];
      end
      m_cnt++;
    end
    m2_q.push_back(e);
    rv_q.push_back(acc & ~we);
    yld = 0;
`ifdef M2_ARB_BURST_LIMIT_EN
    if (acc != 3'b000 && m_cnt == 16 && (req & ~m_gnt) != 3'b000) yld = 1;
    if (m_cnt == 16) m_cnt = 0;
`endif
    nxt = m_owner;
    if (yld) nxt = 3;
    else if (acc == 3'b000) begin
      nxt = 3;
      for (int k = 3; k >= 1; k--)
        if (req[(m_last + k) % 3]) nxt = (m_last + k) % 3;
    end
    if (nxt != m_owner) m_cnt = 0;
    if (nxt != 3) m_last = nxt;
    m_owner = nxt;
    m_gnt   = (nxt == 3) ? 3'b000 : 3'(1 << nxt);
    @(posedge clk);
    @(negedge clk);
    o  = m2_q.pop_front();
    rv = rv_q.pop_front();
    check("gnt",      128'(gnt),    128'(m_gnt));
    check("m2_wen",   128'(M2_WEN), 128'(o.wen));
    check("m2_wad",   128'(M2_WAd), 128'(o.wad));
    check("m2_wdata", M2_WData,     o.wdata);
    check("m2_rad",   128'(M2_RAd), 128'(o.rad));
    check("rvalid",   128'(rvalid), 128'(rv));
  endtask

  initial begin
    logic [2:0]   a;
    int           order[$];
    int           when[$];
    int           n0, first1, last0, t, nrv;
    bit           found;
    logic [127:0] x;

    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Single write from requester 0
    x = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    req = 3'b001; we = 3'b001; addr0 = 8'h2A; wdata0 = x;
    cyc();
    check("w1_gnt", 128'(gnt), 128'(3'b001));
    cyc();
    check("w1_wen",   128'(M2_WEN), 128'(1'b1));
    check("w1_wad",   128'(M2_WAd), 128'(8'h2A));
    check("w1_wdata", M2_WData,     x);
    req = 3'b000;
    repeat (3) cyc();
    check("w1_idle_gnt", 128'(gnt), '0);

    // Back-to-back reads from requester 2
    req = 3'b100; we = 3'b000; addr2 = 8'd5;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (gnt[2]) found = 1;
      else cyc();
    end
    check("rd_gnt_timeout", 128'(found), 128'(1'b1));
    cyc();
    check("rd_rad5", 128'(M2_RAd), 128'(3'd5));
    addr2 = 8'd6;
    cyc();
    check("rd_rad6", 128'(M2_RAd), 128'(3'd6));
    check("rd_rv5",  128'(rvalid), 128'(3'b100));
    req = 3'b000;
    cyc();
    check("rd_rv6", 128'(rvalid), 128'(3'b100));
    repeat (3) cyc();

    // Simultaneous requests, each dropping after one transfer
    @(negedge clk);
    do_reset();
    req = 3'b111; we = 3'b101;
    addr0 = 8'h10; addr1 = 8'h21; addr2 = 8'h33;
    wdata0 = 128'hA0; wdata1 = 128'hA1; wdata2 = 128'hA2;
    t = 0;
    while (req != 3'b000 && t < 20) begin
      a = req & gnt;
      for (int i = 0; i < 3; i++) if (a[i]) begin order.push_back(i); when.push_back(t); end
      cyc();
      req = req & ~a;
      t++;
    end
    check("sim_done",  128'(req), '0);
    check("sim_count", 128'(order.size()), 128'(3));
    if (order.size() == 3) begin
      for (int i = 0; i < 3; i++) check("sim_order", 128'(order[i]), 128'(i));
      check("sim_gap01", 128'(when[1] - when[0]), 128'(2));
      check("sim_gap12", 128'(when[2] - when[1]), 128'(2));
    end
    repeat (3) cyc();

    // Continuous req=011: burst limit behaviour
    @(negedge clk);
    do_reset();
    req = 3'b011; we = 3'b011; addr0 = 8'h40; addr1 = 8'h41;
    n0 = 0; first1 = -1; last0 = -1;
    for (int i = 0; i < 40; i++) begin
      a = req & gnt;
      if (a[1] && first1 < 0) first1 = i;
      if (a[0] && first1 < 0) begin n0++; last0 = i; end
      cyc();
    end
`ifdef M2_ARB_BURST_LIMIT_EN
    check("burst_n0",  128'(n0), 128'(16));
    check("burst_gap", 128'(first1 - last0), 128'(2));
`else
    check("hold_n0",     128'(n0), 128'(39));
    check("hold_no_r1", 128'(first1), 128'(-1));
`endif
    req = 3'b000;
    repeat (2) cyc();

    // Read accepted, then reset in the following cycle
    @(negedge clk);
    do_reset();
    req = 3'b100; we = 3'b000; addr2 = 8'd3;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (gnt[2]) found = 1;
      else cyc();
    end
    check("mr_gnt_timeout", 128'(found), 128'(1'b1));
    cyc();
    check("mr_rad", 128'(M2_RAd), 128'(3'd3));
    do_reset();
    nrv = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (rvalid != 3'b000) nrv++;
    end
    check("mr_no_rvalid", 128'(nrv), '0);

    // Randomised traffic with sticky requests
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) req = 3'($urandom);
      we = 3'($urandom);
      addr0 = 8'($urandom); addr1 = 8'($urandom); addr2 = 8'($urandom);
      wdata0 = {$urandom, $urandom, $urandom, $urandom};
      wdata1 = {$urandom, $urandom, $urandom, $urandom};
      wdata2 = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
